// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - shared constants, FSM encodings and BCD/password helpers for the range cracker
// Macro: CRACK_ASCII_PWD_EN selects ASCII password bytes in pack_pwd (default: raw nibble bytes).
package crack_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int MAX_DIGITS = 8;                       // the md5 core takes an 8-byte password
  localparam int BCD_W = BCD_DIGIT_W * MAX_DIGITS;
  localparam int PWD_W = 8 * MAX_DIGITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_HASH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] MD5_K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Per-round left-rotate amount; it depends only on the round group and i mod 4.
  function automatic logic [4:0] md5_s(input logic [5:0] i);
    logic [4:0] s;
    case ({i[5:4], i[1:0]})
      4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
      4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
      4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
      4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
    endcase
    return s;
  endfunction

  // Adds a small constant (0..16) to a packed-BCD value; returns {carry_out_of_top_digit, sum}.
  function automatic logic [BCD_W:0] bcd_add(input logic [BCD_W-1:0] a, input logic [4:0] k);
    logic [BCD_W-1:0] s;
    logic [4:0] c;
    logic [4:0] t;
    s = '0;
    c = k;
    for (int j = 0; j < MAX_DIGITS; j++) begin
      t = {1'b0, a[BCD_DIGIT_W*j +: BCD_DIGIT_W]} + c;
      if (t >= 5'd20) begin
        s[BCD_DIGIT_W*j +: BCD_DIGIT_W] = 4'(t - 5'd20);
        c = 5'd2;
      end else if (t >= 5'd10) begin
        s[BCD_DIGIT_W*j +: BCD_DIGIT_W] = 4'(t - 5'd10);
        c = 5'd1;
      end else begin
        s[BCD_DIGIT_W*j +: BCD_DIGIT_W] = t[3:0];
        c = 5'd0;
      end
    end
    return {c != 5'd0, s};
  endfunction

  // Digit j lands in byte j, so the most significant digit is the first message byte.
  function automatic logic [PWD_W-1:0] pack_pwd(input logic [BCD_W-1:0] bcd);
    logic [PWD_W-1:0] p;
    p = '0;
    for (int j = 0; j < MAX_DIGITS; j++) begin
`ifdef CRACK_ASCII_PWD_EN
      p[8*j +: 8] = ASCII_ZERO | {4'h0, bcd[BCD_DIGIT_W*j +: BCD_DIGIT_W]};
`else
      p[8*j +: 8] = {4'h0, bcd[BCD_DIGIT_W*j +: BCD_DIGIT_W]};
`endif
    end
    return p;
  endfunction

endpackage

// File: rtl/crack_lane.sv
// rtl/crack_lane.sv - one search lane: password packing, gated md5 core and registered done/match flags
// Ports: clk, rst_n (sync, active-low); run (core released from reset while high); cand (packed BCD);
//        target (digest to match); lane_done / lane_match (registered, cleared while run is low).
module crack_lane
  import crack_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int HASH_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [4*DIGITS-1:0] cand,
  input  logic [HASH_W-1:0]   target,
  output logic                lane_done,
  output logic                lane_match
);

  logic [PWD_W-1:0]  pwd;
  logic [HASH_W-1:0] digest;
  logic              core_done;
  logic              done_q, done_d, match_q, match_d;

  assign pwd = pack_pwd(cand);

  crack_md5 u_md5 (
    .clk     (clk),
    .reset_n (run),
    .pwd     (pwd),
    .done    (core_done),
    .hash    (digest)
  );

  always_comb begin
    done_d  = rst_n && run && core_done;
    match_d = rst_n && run && core_done && (digest == target);
  end

  always_ff @(posedge clk) begin
    done_q  <= done_d;
    match_q <= match_d;
  end

  assign lane_done  = done_q;
  assign lane_match = match_q;

endmodule

// File: rtl/crack_md5.sv
// rtl/crack_md5.sv - iterative single-block MD5 core for an 8-byte password, one round per clock
// Ports: clk; reset_n (sync, low reloads IV and restarts); pwd (byte0 = pwd[63:56]);
//        done (high after 64 rounds, held); hash (digest, first output byte in hash[127:120]).
module crack_md5
  import crack_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [63:0]  pwd,
  output logic         done,
  output logic [127:0] hash
);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [6:0]  i_q, i_d;
  logic [511:0] blk;
  logic [31:0] m0, m1, f, sum;
  logic [3:0]  g;
  logic [5:0]  ri;
  logic [63:0] rot;

  // Words are little-endian; padding bit and 64-bit length complete the single block.
  assign m0  = {pwd[39:32], pwd[47:40], pwd[55:48], pwd[63:56]};
  assign m1  = {pwd[7:0], pwd[15:8], pwd[23:16], pwd[31:24]};
  assign blk = {32'd0, 32'd64, 352'd0, 32'h0000_0080, m1, m0};
  assign ri  = i_q[5:0];

  always_comb begin
    f = '0;
    g = '0;
    case (ri[5:4])
      2'd0: begin f = (b_q & c_q) | (~b_q & d_q); g = ri[3:0]; end
      2'd1: begin f = (d_q & b_q) | (~d_q & c_q); g = ri[3:0] * 4'd5 + 4'd1; end
      2'd2: begin f = b_q ^ c_q ^ d_q;            g = ri[3:0] * 4'd3 + 4'd5; end
      default: begin f = c_q ^ (b_q | ~d_q);     g = ri[3:0] * 4'd7; end
    endcase
    sum = a_q + f + MD5_K[ri] + blk[32*g +: 32];
    rot = {sum, sum} << md5_s(ri);
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; i_d = i_q;
    if (!reset_n) begin
      a_d = IV_A; b_d = IV_B; c_d = IV_C; d_d = IV_D; i_d = '0;
    end else if (!i_q[6]) begin
      a_d = d_q;
      d_d = c_q;
      c_d = b_q;
      b_d = b_q + rot[63:32];
      i_d = i_q + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; i_q <= i_d;
  end

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign done = i_q[6];
  assign hash = {bswap(a_q + IV_A), bswap(b_q + IV_B), bswap(c_q + IV_C), bswap(d_q + IV_D)};

endmodule

// File: rtl/crack_multi_lane.sv
// rtl/crack_multi_lane.sv - LANES-wide brute-force MD5 preimage search over a packed-BCD range
// Macro: CRACK_ASCII_PWD_EN (ASCII password bytes; default raw nibble bytes).
// Ports: clk, rst_n (sync, active-low); start (pulse, IDLE/DONE only); abort (level);
//        lower_bound/upper_bound (packed BCD, inclusive); hash_answer (target digest);
//        answer, answer_found, done (held until next start), busy (LOAD/CHECK/HASH).
module crack_multi_lane
  import crack_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DIGITS = 8,
  parameter int HASH_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [4*DIGITS-1:0] lower_bound,
  input  logic [4*DIGITS-1:0] upper_bound,
  input  logic [HASH_W-1:0]   hash_answer,
  output logic [4*DIGITS-1:0] answer,
  output logic                answer_found,
  output logic                done,
  output logic                busy
);

  localparam int BW = 4 * DIGITS;

  logic [2:0]        state_q, state_d;
  logic [BW-1:0]     base_q, base_d, upper_q, upper_d, answer_q, answer_d;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [LANES-1:0]  en_q, en_d;
  logic              found_q, found_d, done_q, done_d, wrap_q, wrap_d;

  logic [BW-1:0]     cand [LANES];
  logic [LANES-1:0]  en_now, lane_run, lane_done, lane_match;
  logic [BW:0]       nxt;
  logic [BW-1:0]     sel;
  logic              all_done;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [BW:0] sum;
    assign sum       = bcd_add(base_q, 5'(k));
    assign cand[k]   = sum[BW-1:0];
    // wrap_q marks a base that already ran off the top digit; nothing after it is in range.
    assign en_now[k] = !sum[BW] && (sum[BW-1:0] <= upper_q) && !wrap_q;
    // Cores sit in reset through CHECK and are released only for enabled lanes in HASH.
    assign lane_run[k] = rst_n && (state_q == S_HASH) && en_q[k];

    crack_lane #(.DIGITS(DIGITS), .HASH_W(HASH_W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (lane_run[k]),
      .cand       (cand[k]),
      .target     (hash_q),
      .lane_done  (lane_done[k]),
      .lane_match (lane_match[k])
    );
  end

  assign nxt      = bcd_add(base_q, 5'(LANES));
  assign all_done = &(lane_done | ~en_q);

  always_comb begin
    sel = cand[0];
    for (int k = LANES - 1; k >= 0; k--) begin
      if (lane_match[k]) sel = cand[k];
    end
  end

  always_comb begin
    state_d = state_q; base_d = base_q; upper_d = upper_q; hash_d = hash_q;
    en_d = en_q; answer_d = answer_q; found_d = found_q; done_d = done_q; wrap_d = wrap_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          base_d  = lower_bound;
          upper_d = upper_bound;
          hash_d  = hash_answer;
          found_d = 1'b0;
          done_d  = 1'b0;
          wrap_d  = 1'b0;
          en_d    = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_DONE; done_d = 1'b1; answer_d = base_q;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort || !en_now[0]) begin
          state_d = S_DONE; done_d = 1'b1; answer_d = base_q;
        end else begin
          en_d    = en_now;
          state_d = S_HASH;
        end
      end
      S_HASH: begin
        // A match in the completion cycle takes priority over abort.
        if (all_done && |lane_match) begin
          state_d = S_DONE; done_d = 1'b1; found_d = 1'b1; answer_d = sel;
        end else if (abort || (all_done && !(&en_q))) begin
          state_d = S_DONE; done_d = 1'b1; answer_d = base_q;
        end else if (all_done) begin
          state_d = S_CHECK;
          // On carry-out keep the last in-range base so the next CHECK ends the search on it.
          if (nxt[BW]) wrap_d = 1'b1;
          else         base_d = nxt[BW-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      state_d = S_IDLE; base_d = '0; upper_d = '0; hash_d = '0; en_d = '0;
      answer_d = '0; found_d = 1'b0; done_d = 1'b0; wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    base_q   <= base_d;
    upper_q  <= upper_d;
    hash_q   <= hash_d;
    en_q     <= en_d;
    answer_q <= answer_d;
    found_q  <= found_d;
    done_q   <= done_d;
    wrap_q   <= wrap_d;
  end

  assign answer       = answer_q;
  assign answer_found = found_q;
  assign done         = done_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_CHECK) || (state_q == S_HASH);

endmodule

// File: tb/tb_crack_multi_lane.sv
// tb/tb_crack_multi_lane.sv - scoreboard bench for crack_multi_lane with a reference MD5 model
module tb_crack_multi_lane;

  logic         clk = 1'b0;
  logic         rst_n, start, abort;
  logic [31:0]  lower_bound, upper_bound;
  logic [127:0] hash_answer;
  logic [31:0]  answer;
  logic         answer_found, done, busy;

  always #5 clk = ~clk;

  crack_multi_lane #(.LANES(4), .DIGITS(8), .HASH_W(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .lower_bound  (lower_bound),
    .upper_bound  (upper_bound),
    .hash_answer  (hash_answer),
    .answer       (answer),
    .answer_found (answer_found),
    .done         (done),
    .busy         (busy)
  );

  typedef struct {
    logic [31:0] ans;
    logic        found;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ktab [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] bs(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] bcd2pwd(input logic [31:0] bcd);
    logic [63:0] p;
    for (int j = 0; j < 8; j++) begin
`ifdef CRACK_ASCII_PWD_EN
      p[8*j +: 8] = 8'h30 + {4'h0, bcd[4*j +: 4]};
`else
      p[8*j +: 8] = {4'h0, bcd[4*j +: 4]};
`endif
    end
    return p;
  endfunction

  function automatic logic [127:0] md5_ref(input logic [63:0] pwd);
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t;
    int g, s;
    int sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    for (int j = 0; j < 16; j++) m[j] = 32'd0;
    m[0]  = {pwd[39:32], pwd[47:40], pwd[55:48], pwd[63:56]};
    m[1]  = {pwd[7:0], pwd[15:8], pwd[23:16], pwd[31:24]};
    m[2]  = 32'h80;
    m[14] = 32'd64;
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      s = sh[(i / 16) * 4 + (i % 4)];
      t = a + f + ktab[i] + m[g];
      a = d; d = c; c = b;
      b = b + ((t << s) | (t >> (32 - s)));
    end
    return {bs(a + 32'h67452301), bs(b + 32'hefcdab89), bs(c + 32'h98badcfe), bs(d + 32'h10325476)};
  endfunction

  // Monitor: every rising edge of done consumes one scoreboard entry.
  logic done_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_answer"}, 64'(answer), 64'(e.ans));
          check({e.name, "_found"}, 64'(answer_found), 64'(e.found));
        end
      end
      done_prev = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] tgt);
    lower_bound = lo;
    upper_bound = hi;
    hash_answer = md5_ref(bcd2pwd(tgt));
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick(1);
      n++;
    end
    check({name, "_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic run_search(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] tgt,
                            input logic [31:0] ans, input logic found, input string name);
    exp_q.push_back('{ans, found, name});
    issue(lo, hi, tgt);
    wait_done(name, 600);
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      ktab[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    lower_bound = '0; upper_bound = '0; hash_answer = '0;
    tick(3);
    check("reset_answer", 64'(answer), 64'd0);
    check("reset_found", 64'(answer_found), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick(2);

    run_search(32'h00001230, 32'h00001240, 32'h00001234, 32'h00001234, 1'b1, "round2_lane0");
    tick(5);
    check("done_held", 64'(done), 64'd1);
    check("answer_held", 64'(answer), 64'h00001234);

    run_search(32'h00001230, 32'h00001240, 32'h00001233, 32'h00001233, 1'b1, "round1_lane3");
    run_search(32'h00000000, 32'h00000005, 32'h00000009, 32'h00000004, 1'b0, "upper_mask");
    run_search(32'h99999998, 32'h99999999, 32'h99999997, 32'h99999998, 1'b0, "carry_mask");

    // Abort a few cycles into HASH; done must follow on the very next edge.
    exp_q.push_back('{32'h00001230, 1'b0, "abort"});
    issue(32'h00001230, 32'h00001240, 32'h00001234);
    tick(5);
    check("abort_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick(1);
    check("abort_latency", 64'(done), 64'd1);
    abort = 1'b0;
    tick(2);
    run_search(32'h00000000, 32'h00000003, 32'h00000002, 32'h00000002, 1'b1, "restart");

    // Reset in the middle of a search clears everything without a done pulse.
    issue(32'h00001230, 32'h00001240, 32'h00001234);
    tick(10);
    rst_n = 1'b0;
    tick(1);
    check("midreset_answer", 64'(answer), 64'd0);
    check("midreset_found", 64'(answer_found), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick(3);
    check("midreset_no_done", 64'(done), 64'd0);

    begin
      int n = 1;
      exp_q.push_back('{32'h00000050, 1'b0, "inverted_range"});
      issue(32'h00000050, 32'h00000040, 32'h00000000);
      while (!done && n < 10) begin
        tick(1);
        n++;
      end
      check("inverted_latency", 64'(n <= 3), 64'd1);
    end
    tick(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
